pipelined_ctrl_path: RTL and testbench

PIPELINED_CTRL_PATH -- requirements
Module: pipelined_ctrl_path

---
 rtl/rvscc_ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decoder.sv | 77 +++++++
 rtl/pipelined_ctrl_path.sv | 117 +++++++++++
 tb/tb_pipelined_ctrl_path.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rvscc_ctrl_pkg.sv
// rtl/rvscc_ctrl_pkg.sv - shared opcodes, encodings and control bundle for the control path
package rvscc_ctrl_pkg;

    // Major opcodes understood by the decoder
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU operation encoding; M-ops occupy 8..15 as 8 + funct3
    localparam int         ALU_W   = 4;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    // Result source encoding
    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    // Immediate formats; J and U share a code, the extender tells them apart by opcode
    localparam logic [1:0] IMM_I  = 2'd0;
    localparam logic [1:0] IMM_S  = 2'd1;
    localparam logic [1:0] IMM_B  = 2'd2;
    localparam logic [1:0] IMM_JU = 2'd3;

    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic             branch_neg;
        logic [ALU_W-1:0] alu_ctrl;
        logic             alu_src;
        logic             m_op;
        logic             illegal;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Base-ISA ALU op from funct3; sub selects SUB for funct3 000 (R-type only)
    function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  alu_from_funct3 = sub ? ALU_SUB : ALU_ADD;
            3'b010:  alu_from_funct3 = ALU_SLT;
            3'b100:  alu_from_funct3 = ALU_XOR;
            3'b110:  alu_from_funct3 = ALU_OR;
            3'b111:  alu_from_funct3 = ALU_AND;
            default: alu_from_funct3 = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational D-stage instruction decoder
//
// Ports:
//   opcode_i, funct3_i, funct7_i  instruction fields in D
//   ctrl_o                        decoded control bundle (BUBBLE with illegal=1 if unknown)
//   imm_src_o                     immediate format for the D-stage extender
module ctrl_decoder
    import rvscc_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output ctrl_t      ctrl_o,
    output logic [1:0] imm_src_o
);

    always_comb begin
        ctrl_o    = BUBBLE;
        imm_src_o = IMM_I;
        case (opcode_i)
            OP_R: begin
                if (funct7_i == F7_MULDIV) begin
                    if (EN_M) begin
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.alu_ctrl  = {1'b1, funct3_i};
                        ctrl_o.m_op      = 1'b1;
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end else begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_ctrl  = alu_from_funct3(funct3_i, funct7_i[5]);
                end
            end
            OP_IMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_ctrl  = alu_from_funct3(funct3_i, 1'b0);
                imm_src_o        = IMM_I;
            end
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_MEM;
                imm_src_o         = IMM_I;
            end
            OP_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_src_o        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl_o.branch     = 1'b1;
                ctrl_o.branch_neg = funct3_i[0];
                ctrl_o.alu_ctrl   = ALU_SUB;
                imm_src_o         = IMM_B;
            end
            OP_JAL: begin
                ctrl_o.jump       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_PC4;
                imm_src_o         = IMM_JU;
            end
            OP_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_src_o        = IMM_JU;
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_ctrl_path.sv
// rtl/pipelined_ctrl_path.sv - D/E/M/W control pipeline with multi-cycle M-op hold
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   opcode_d, funct3_d, funct7_d    instruction fields in D
//   stall_d, flush_e                hazard-unit controls (bubble into E / kill E)
//   zero_e                          ALU zero flag for the instruction in E
//   imm_src_d                       D-stage immediate format (combinational)
//   alu_ctrl_e, alu_src_e,
//   result_src_e                    E-stage controls
//   pc_src_e                        taken branch or jump in E
//   busy_e                          M-op still occupying E
//   mem_write_m, reg_write_m        M-stage controls
//   reg_write_w, result_src_w,
//   illegal_w                       W-stage controls
module pipelined_ctrl_path
    import rvscc_ctrl_pkg::*;
#(
    parameter bit EN_M        = 1'b1,
    parameter int MUL_LATENCY = 4,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode_d,
    input  logic [2:0]            funct3_d,
    input  logic [6:0]            funct7_d,
    input  logic                  stall_d,
    input  logic                  flush_e,
    input  logic                  zero_e,
    output logic [1:0]            imm_src_d,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
    output logic                  alu_src_e,
    output logic [1:0]            result_src_e,
    output logic                  pc_src_e,
    output logic                  busy_e,
    output logic                  mem_write_m,
    output logic                  reg_write_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic                  illegal_w
);

    // Counter counts the remaining extra E cycles of an M-op
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

    ctrl_t      dec_ctrl;
    ctrl_t      e_q, e_d;
    ctrl_t      m_q, m_d;
    ctrl_t      w_q;
    logic [3:0] cnt_q, cnt_d;
    logic       pc_src;
    logic       busy;

    ctrl_decoder #(
        .EN_M(EN_M)
    ) u_dec (
        .opcode_i (opcode_d),
        .funct3_i (funct3_d),
        .funct7_i (funct7_d),
        .ctrl_o   (dec_ctrl),
        .imm_src_o(imm_src_d)
    );

    assign busy   = (cnt_q != 4'd0);
    assign pc_src = (e_q.branch & (zero_e ^ e_q.branch_neg)) | e_q.jump;

    // A redirect or flush outranks the M-op hold so an aborted multiply frees E at once
    always_comb begin
        e_d   = dec_ctrl;
        cnt_d = 4'd0;
        if (flush_e || pc_src) begin
            e_d = BUBBLE;
        end else if (busy) begin
            e_d   = e_q;
            cnt_d = cnt_q - 4'd1;
        end else if (stall_d) begin
            e_d = BUBBLE;
        end else begin
            e_d   = dec_ctrl;
            cnt_d = dec_ctrl.m_op ? CNT_LOAD : 4'd0;
        end
    end

    // The M-op only leaves E on its final cycle, so M sees it exactly once
    assign m_d = busy ? BUBBLE : e_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q   <= BUBBLE;
            m_q   <= BUBBLE;
            w_q   <= BUBBLE;
            cnt_q <= 4'd0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= m_q;
            cnt_q <= cnt_d;
        end
    end

    assign alu_ctrl_e   = ALU_CTRL_W'(e_q.alu_ctrl);
    assign alu_src_e    = e_q.alu_src;
    assign result_src_e = e_q.result_src;
    assign pc_src_e     = pc_src;
    assign busy_e       = busy;
    assign mem_write_m  = m_q.mem_write;
    assign reg_write_m  = m_q.reg_write;
    assign reg_write_w  = w_q.reg_write;
    assign result_src_w = w_q.result_src;
    assign illegal_w    = w_q.illegal;

    // Full bundles travel through M and W; fields no later stage consumes are collected here
    logic unused_fields;
    assign unused_fields = ^{e_q.m_op, m_q, w_q};

endmodule

// File: tb/tb_pipelined_ctrl_path.sv
// tb/tb_pipelined_ctrl_path.sv - scoreboard bench with instruction-level reference model
module tb_pipelined_ctrl_path;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode_d = '0;
    logic [2:0] funct3_d = '0;
    logic [6:0] funct7_d = '0;
    logic       stall_d = 1'b0, flush_e = 1'b0, zero_e = 1'b0;

    logic [1:0] imm_src_d, result_src_e, result_src_w;
    logic [3:0] alu_ctrl_e;
    logic       alu_src_e, pc_src_e, busy_e, mem_write_m, reg_write_m, reg_write_w, illegal_w;

    logic [1:0] n_imm_src_d, n_result_src_e, n_result_src_w;
    logic [3:0] n_alu_ctrl_e;
    logic       n_alu_src_e, n_pc_src_e, n_busy_e, n_mem_write_m, n_reg_write_m, n_reg_write_w, n_illegal_w;

    pipelined_ctrl_path #(.EN_M(1'b1), .MUL_LATENCY(LAT), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .opcode_d(opcode_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
        .stall_d(stall_d), .flush_e(flush_e), .zero_e(zero_e), .imm_src_d(imm_src_d),
        .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e), .result_src_e(result_src_e),
        .pc_src_e(pc_src_e), .busy_e(busy_e), .mem_write_m(mem_write_m), .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w), .result_src_w(result_src_w), .illegal_w(illegal_w)
    );

    pipelined_ctrl_path #(.EN_M(1'b0), .MUL_LATENCY(LAT), .ALU_CTRL_W(4)) dut_nm (
        .clk(clk), .rst(rst), .opcode_d(opcode_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
        .stall_d(stall_d), .flush_e(flush_e), .zero_e(zero_e), .imm_src_d(n_imm_src_d),
        .alu_ctrl_e(n_alu_ctrl_e), .alu_src_e(n_alu_src_e), .result_src_e(n_result_src_e),
        .pc_src_e(n_pc_src_e), .busy_e(n_busy_e), .mem_write_m(n_mem_write_m), .reg_write_m(n_reg_write_m),
        .reg_write_w(n_reg_write_w), .result_src_w(n_result_src_w), .illegal_w(n_illegal_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int alu;   // -1: not checked
        int imm;   // -1: not checked
        int rs;
        bit rw, mw, br, neg, jmp, ill, mop, asrc, abort;
    } ins_t;

    typedef struct {
        int due;
        bit rw;
        int rs;
        bit ill;
    } ret_t;

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   nm_due = -1;
    ret_t rq[$];
    int   sq[$];
    int   dir[$] = '{0, 6, 0, 0, 7, 0, 10, 0, 10, 0};
    int   mul_cnt = 0;

    ins_t cur, e;
    bit   e_v = 1'b0;
    int   e_left = 0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic ins_t make_ins(input int kind);
        ins_t i;
        logic [6:0] ill_ops [4];
        ill_ops = '{7'b1110011, 7'b0001111, 7'b1100111, 7'b0010111};
        i = '{op: 7'd0, f3: 3'd0, f7: 7'd0, alu: 0, imm: -1, rs: 0,
              rw: 0, mw: 0, br: 0, neg: 0, jmp: 0, ill: 0, mop: 0, asrc: 0, abort: 0};
        case (kind)
            0:  begin i.op = 7'b0110011; i.rw = 1; end
            1:  begin i.op = 7'b0110011; i.f7 = 7'b0100000; i.alu = 1; i.rw = 1; end
            2:  begin i.op = 7'b0110011; i.f3 = 3'b010; i.alu = 5; i.rw = 1; end
            3:  begin i.op = 7'b0010011; i.rw = 1; i.asrc = 1; i.imm = 0; end
            4:  begin i.op = 7'b0000011; i.f3 = 3'b010; i.rw = 1; i.asrc = 1; i.rs = 1; i.imm = 0; end
            5:  begin i.op = 7'b0100011; i.f3 = 3'b010; i.mw = 1; i.asrc = 1; i.imm = 1; end
            6:  begin i.op = 7'b1100011; i.br = 1; i.alu = 1; i.imm = 2; end
            7:  begin i.op = 7'b1100011; i.f3 = 3'b001; i.br = 1; i.neg = 1; i.alu = 1; i.imm = 2; end
            8:  begin i.op = 7'b1101111; i.jmp = 1; i.rw = 1; i.rs = 2; i.alu = -1; i.imm = 3; end
            9:  begin i.op = 7'b0110111; i.rw = 1; i.asrc = 1; i.alu = -1; i.imm = 3; end
            10: begin i.op = 7'b0110011; i.f7 = 7'b0000001; i.alu = 8; i.rw = 1; i.mop = 1; end
            11: begin
                i.op = 7'b0110011; i.f7 = 7'b0000001; i.f3 = 3'($urandom_range(0, 7));
                i.alu = 8 + int'(i.f3); i.rw = 1; i.mop = 1;
            end
            default: begin i.op = ill_ops[$urandom_range(0, 3)]; i.ill = 1; end
        endcase
        return i;
    endfunction

    function automatic ins_t next_ins();
        ins_t i;
        int   k;
        if (dir.size() > 0) begin
            k = dir.pop_front();
            i = make_ins(k);
            if (k == 10) begin
                mul_cnt++;
                i.abort = (mul_cnt == 2);
            end
        end else begin
            k = $urandom_range(0, 15);
            if (k >= 14)      i = make_ins(12);
            else if (k >= 12) i = make_ins(0);
            else              i = make_ins(k);
        end
        return i;
    endfunction

    function automatic int all_outs();
        return int'({alu_ctrl_e, alu_src_e, result_src_e, pc_src_e, busy_e,
                     mem_write_m, reg_write_m, reg_write_w, result_src_w, illegal_w});
    endfunction

    // Monitor: pops expected retirements when the DUT shows them and flags late/missing ones
    always @(negedge clk) begin
        ret_t r;
        if (mon_en && !rst) begin
            if (reg_write_w || illegal_w || result_src_w != 2'd0) begin
                if (rq.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    r = rq.pop_front();
                    check("w_cycle", cyc, r.due);
                    check("reg_write_w", int'(reg_write_w), int'(r.rw));
                    check("result_src_w", int'(result_src_w), r.rs);
                    check("illegal_w", int'(illegal_w), int'(r.ill));
                end
            end
            while (rq.size() > 0 && rq[0].due < cyc) begin
                void'(rq.pop_front());
                check("w_missing", 0, 1);
            end
            if (mem_write_m) begin
                if (sq.size() == 0) check("store_unexpected", 1, 0);
                else                check("store_cycle", cyc, sq.pop_front());
            end
            while (sq.size() > 0 && sq[0] < cyc) begin
                void'(sq.pop_front());
                check("store_missing", 0, 1);
            end
            if (cyc == nm_due) begin
                check("nm_illegal_w", int'(n_illegal_w), 1);
                check("nm_reg_write_w", int'(n_reg_write_w), 0);
            end
        end
    end

    initial begin
        bit taken, busy, did_rst, clean;
        did_rst = 1'b0;
        clean   = 1'b0;
        #2;
        check("reset_outputs", all_outs(), 0);
        @(posedge clk);
        #1;
        check("reset_outputs_held", all_outs(), 0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        cur    = next_ins();

        for (int it = 0; it < 520; it++) begin
            opcode_d = cur.op;
            funct3_d = cur.f3;
            funct7_d = cur.f7;
            if (it >= 500) begin
                stall_d = 1'b1; flush_e = 1'b0; zero_e = 1'b0;
            end else if (it < 30 || clean) begin
                stall_d = 1'b0;
                zero_e  = 1'b1;
                flush_e = e_v && e.abort && (e_left == LAT - 1);
            end else begin
                stall_d = ($urandom_range(0, 7) == 0);
                flush_e = ($urandom_range(0, 15) == 0);
                zero_e  = 1'($urandom_range(0, 1));
            end
            clean = 1'b0;
            if (cur.mop && nm_due < 0 && !stall_d && !flush_e) nm_due = cyc + 3;

            taken = e_v && ((e.br && (zero_e ^ e.neg)) || e.jmp);
            busy  = e_v && e.mop && (e_left > 1);
            #1;
            check("pc_src_e", int'(pc_src_e), int'(taken));
            check("busy_e", int'(busy_e), int'(busy));
            if (!e_v || e.alu >= 0) check("alu_ctrl_e", int'(alu_ctrl_e), e_v ? e.alu : 0);
            check("alu_src_e", int'(alu_src_e), e_v ? int'(e.asrc) : 0);
            check("result_src_e", int'(result_src_e), e_v ? e.rs : 0);
            if (cur.imm >= 0) check("imm_src_d", int'(imm_src_d), cur.imm);

            @(posedge clk);
            if (e_v && !busy) begin
                if (e.rw || e.ill) rq.push_back('{due: cyc + 2, rw: e.rw, rs: e.rs, ill: e.ill});
                if (e.mw) sq.push_back(cyc + 1);
            end
            if (flush_e || taken) begin
                e_v = 1'b0;
            end else if (busy) begin
                e_left--;
            end else if (stall_d) begin
                e_v = 1'b0;
            end else begin
                e      = cur;
                e_v    = 1'b1;
                e_left = cur.mop ? LAT : 1;
            end
            if (flush_e || taken || (!busy && !stall_d)) cur = next_ins();
            cyc++;

            if (!did_rst && it >= 30 && it < 500 && e_v && e.mop && e_left == LAT - 1) begin
                did_rst = 1'b1;
                #3;
                check("busy_before_reset", int'(busy_e), 1);
                rst = 1'b1;
                #1;
                check("reset_mid_mul", all_outs(), 0);
                e_v = 1'b0;
                rq.delete();
                sq.delete();
                @(posedge clk);
                cyc++;
                @(negedge clk);
                rst   = 1'b0;
                cur   = make_ins(0);
                clean = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("reset_mid_mul_done", int'(did_rst), 1);
        check("queues_drained", rq.size() + sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
